// File: rtl/video_frame_meter.sv
// Receive-side frame geometry meter for the di/de/hs/vs pixel stream.
// Reports first-line width, non-empty line count, pixel checksum and a consistency flag per frame.
module video_frame_meter #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [CNT_WIDTH-1:0]   meas_w_o,
  output logic [CNT_WIDTH-1:0]   meas_h_o,
  output logic [31:0]            meas_sum_o,
  output logic                   meas_err_o,
  output logic                   meas_vld_o,
  output logic [15:0]            frame_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LINE, HBLANK} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state;
  logic                 sr_hs, sr_vs;
  logic [CNT_WIDTH-1:0] pix_cnt, ref_w, line_cnt;
  logic                 have_ref;
  logic [31:0]          sum;
  logic                 err;

  logic vs_rise, vs_fall, hs_rise, hs_fall;
  logic in_frame, accept, close_line, line_nz, first_line;
  logic mism, line_sat, pix_sat, frame_close, err_next;
  logic [CNT_WIDTH-1:0] w_next, h_next;

  // Edge detect and per-cycle decisions
  always_comb begin
    vs_rise     = vs_i & ~sr_vs;
    vs_fall     = ~vs_i & sr_vs;
    hs_fall     = ~hs_i & sr_hs;
    hs_rise     = hs_i & ~sr_hs;
    in_frame    = (state != IDLE);
    accept      = de_i & ~hs_i & vs_i & (in_frame | vs_rise);
    close_line  = (state == LINE) & (hs_rise | vs_fall);
    line_nz     = close_line & (pix_cnt != '0);
    first_line  = line_nz & ~have_ref;
    mism        = line_nz & have_ref & (pix_cnt != ref_w);
    line_sat    = line_nz & (line_cnt == CNT_MAX);
    pix_sat     = accept & (pix_cnt == CNT_MAX);
    w_next      = first_line ? pix_cnt : ref_w;
    h_next      = line_nz ? sat_inc(line_cnt) : line_cnt;
    err_next    = err | mism | line_sat | pix_sat;
    frame_close = in_frame & vs_fall;
  end

  // Registered state, accumulators and measurement outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr_hs       <= 1'b1;
      sr_vs       <= 1'b1;
      pix_cnt     <= '0;
      ref_w       <= '0;
      have_ref    <= 1'b0;
      line_cnt    <= '0;
      sum         <= '0;
      err         <= 1'b0;
      meas_w_o    <= '0;
      meas_h_o    <= '0;
      meas_sum_o  <= '0;
      meas_err_o  <= 1'b0;
      meas_vld_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      sr_hs      <= hs_i;
      sr_vs      <= vs_i;
      meas_vld_o <= 1'b0;

      case (state)
        IDLE:    if (vs_rise) state <= hs_i ? HBLANK : LINE;
        LINE:    if (vs_fall) state <= IDLE; else if (hs_rise) state <= HBLANK;
        HBLANK:  if (vs_fall) state <= IDLE; else if (hs_fall) state <= LINE;
        default: state <= IDLE;
      endcase

      if (frame_close) begin
        meas_w_o    <= w_next;
        meas_h_o    <= h_next;
        meas_sum_o  <= sum;
        meas_err_o  <= err_next;
        meas_vld_o  <= 1'b1;
        frame_cnt_o <= frame_cnt_o + 16'd1;
        pix_cnt     <= '0;
        ref_w       <= '0;
        have_ref    <= 1'b0;
        line_cnt    <= '0;
        sum         <= '0;
        err         <= 1'b0;
      end else begin
        if (accept) begin
          pix_cnt <= sat_inc(pix_cnt);
          sum     <= sum + 32'(di_i);
        end
        // Closing cycles never accept a pixel (hs or vs is inactive), so the clear cannot lose one
        if (close_line) pix_cnt <= '0;
        if (first_line) begin
          ref_w    <= pix_cnt;
          have_ref <= 1'b1;
        end
        line_cnt <= h_next;
        err      <= err_next;
      end
    end
  end

endmodule
